// File: rtl/tx_frame_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// freq_meter_pkg
// Shared definitions for the measurement-to-UART framing path.
//   FRAME_HEADER  : sync byte that opens every frame
//   sched_state_t : scheduler FSM states
//   frame_len()   : bytes per frame for a given payload width
// ---------------------------------------------------------------------------
package freq_meter_pkg;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        START,
        WAIT
    } sched_state_t;

    // HEADER + channel ID + payload bytes + checksum
    function automatic int frame_len(input int word_w);
        return 3 + word_w / 8;
    endfunction

endpackage

// File: rtl/tx_frame_scheduler_if.sv
// ---------------------------------------------------------------------------
// tx_frame_scheduler_if
// Bundles the requester side and the transmitter side of the scheduler.
//   req        : level request per channel; req_data valid while high
//   req_data   : channel i word at [i*WORD_W +: WORD_W]
//   req_ack    : one-cycle pulse, channel word latched and frame queued
//   tx_start   : start request to the byte transmitter
//   tx_data    : byte for the transmitter, stable while tx_start is high
//   tx_busy    : transmitter busy
//   frame_busy : high from grant until the last byte's tx_busy falls
//
// Handshake: a requester holds req (and its req_data) until it sees its
// req_ack bit; the scheduler samples req only while idle. On the byte side,
// tx_start is held with tx_data stable until tx_busy is observed high, and a
// new byte is only offered after tx_busy has been observed low again.
// ---------------------------------------------------------------------------
interface tx_frame_scheduler_if #(
    parameter int N_REQ  = 3,
    parameter int WORD_W = 32
) ();
    logic [N_REQ-1:0]        req;
    logic [N_REQ*WORD_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ack;
    logic                    tx_start;
    logic [7:0]              tx_data;
    logic                    tx_busy;
    logic                    frame_busy;

    modport master (
        input  req, req_data, tx_busy,
        output req_ack, tx_start, tx_data, frame_busy
    );

    modport slave (
        output req, req_data, tx_busy,
        input  req_ack, tx_start, tx_data, frame_busy
    );
endinterface

// File: rtl/tx_frame_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: first set request bit scanning upward
// from ptr, wrapping at N. The pointer register lives in the caller.
//   req       : request vector
//   ptr       : index with highest priority this round (must be < N)
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : index of the granted bit
//   any       : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any
);
    logic found;

    // Two passes: indices at/above ptr first, then the wrapped-around ones.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        any       = |req;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = PW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = PW'(i);
            end
        end
    end
endmodule

// File: rtl/tx_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tx_frame_scheduler
// Shares one UART byte transmitter among N_REQ measurement producers.
// Each grant latches one producer's word and sends the frame
//   HEADER, ID, word bytes (MSB first), XOR checksum (ID + data bytes)
// through the transmitter's start/busy handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester + transmitter signals (master side)
//   fsm_state  : current scheduler state, for observation
// ---------------------------------------------------------------------------
module tx_frame_scheduler
    import freq_meter_pkg::*;
#(
    parameter int         N_REQ  = 3,
    parameter int         WORD_W = 32,
    parameter logic [7:0] HEADER = FRAME_HEADER
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tx_frame_scheduler_if.master  bus,
    output sched_state_t          fsm_state
);
    localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int NB  = WORD_W / 8;
    localparam int LEN = frame_len(WORD_W);
    localparam int IW  = $clog2(LEN);

    sched_state_t      state;
    logic [PW-1:0]     ptr;
    logic [WORD_W-1:0] word;
    logic [PW-1:0]     id;
    logic [IW-1:0]     byte_idx;
    logic [7:0]        csum;
    logic [7:0]        cur_byte;
    logic              last_byte;

    logic [N_REQ-1:0]  grant;
    logic [PW-1:0]     grant_idx;
    logic              any_req;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req       (bus.req),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    // Byte mux: the last index falls through to the running checksum.
    always_comb begin
        cur_byte = csum;
        if (byte_idx == '0) begin
            cur_byte = HEADER;
        end else if (byte_idx == IW'(1)) begin
            cur_byte = 8'(id);
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (byte_idx == IW'(i + 2)) begin
                    cur_byte = word[WORD_W-1-8*i -: 8];
                end
            end
        end
    end

    assign last_byte = (byte_idx == IW'(LEN - 1));
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            ptr            <= '0;
            word           <= '0;
            id             <= '0;
            byte_idx       <= '0;
            csum           <= '0;
            bus.req_ack    <= '0;
            bus.tx_start   <= 1'b0;
            bus.tx_data    <= '0;
            bus.frame_busy <= 1'b0;
        end else begin
            bus.req_ack <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        bus.req_ack    <= grant;
                        word           <= bus.req_data[int'(grant_idx)*WORD_W +: WORD_W];
                        id             <= grant_idx;
                        byte_idx       <= '0;
                        csum           <= '0;
                        bus.frame_busy <= 1'b1;
                        ptr            <= (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        state          <= LOAD;
                    end
                end
                // Busy may still be high from the previous byte or from a
                // transmitter that was already running at grant time.
                LOAD: begin
                    if (!bus.tx_busy) begin
                        bus.tx_data  <= cur_byte;
                        bus.tx_start <= 1'b1;
                        if ((byte_idx != '0) && !last_byte) begin
                            csum <= csum ^ cur_byte;
                        end
                        state <= START;
                    end
                end
                // The transmitter samples start only on its baud tick.
                START: begin
                    if (bus.tx_busy) begin
                        bus.tx_start <= 1'b0;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (!bus.tx_busy) begin
                        if (last_byte) begin
                            bus.frame_busy <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tx_frame_scheduler
// Directed bench for tx_frame_scheduler. dut0 uses the default 3 x 32-bit
// configuration, dut1 a 2 x 16-bit configuration. Stimulus pushes the
// expected bytes and acks into queues; monitor processes pop and compare
// whenever the DUT presents a byte or an ack.
// ---------------------------------------------------------------------------
module tb_tx_frame_scheduler;
    import freq_meter_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 0 : N_REQ=3, WORD_W=32 ----------------
    tx_frame_scheduler_if #(.N_REQ(3), .WORD_W(32)) bus0 ();
    sched_state_t state0;
    logic model_busy0 = 1'b0;
    logic hold_busy   = 1'b0;
    assign bus0.tx_busy = model_busy0 | hold_busy;

    tx_frame_scheduler #(.N_REQ(3), .WORD_W(32)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus0),
        .fsm_state (state0)
    );

    // ---------------- DUT 1 : N_REQ=2, WORD_W=16 ----------------
    tx_frame_scheduler_if #(.N_REQ(2), .WORD_W(16)) bus1 ();
    sched_state_t state1;
    logic busy1 = 1'b0;
    assign bus1.tx_busy = busy1;

    tx_frame_scheduler #(.N_REQ(2), .WORD_W(16)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus1),
        .fsm_state (state1)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    logic [2:0] ack_q[$];
    logic [7:0] exp1_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int start_delay = 1;
    int bytes_seen  = 0;
    int acks_seen   = 0;
    int busy_falls  = 0;

    localparam logic [31:0] W0 = 32'hDEADBEEF;
    localparam logic [31:0] W1 = 32'h12345678;
    localparam logic [31:0] W2 = 32'h0F1E2D3C;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got event with nothing expected", name);
    endtask

    // Reference frame for a 32-bit word on dut0.
    task automatic push_frame(input int id, input logic [31:0] w);
        logic [7:0] cs;
        logic [7:0] b;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(id));
        cs = 8'(id);
        for (int k = 3; k >= 0; k--) begin
            b = w[8*k +: 8];
            exp_q.push_back(b);
            cs = cs ^ b;
        end
        exp_q.push_back(cs);
        ack_q.push_back(3'b001 << id);
    endtask

    // ---------------- transmitter model for dut0 ----------------
    // Raises busy start_delay cycles after tx_start appears, then stays busy
    // for a short random time.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus0.tx_start && !model_busy0) begin
                repeat (start_delay - 1) @(negedge clk);
                model_busy0 = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                model_busy0 = 1'b0;
            end
        end
    end

    // ---------------- monitor for dut0 ----------------
    logic prev_start = 1'b0;
    logic prev_busy  = 1'b0;
    logic [7:0] held;
    int hold_cnt = 0;
    logic data_moved = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_start = 1'b0;
            prev_busy  = 1'b0;
            data_moved = 1'b0;
        end else begin
            if (bus0.tx_start && !prev_start) begin
                if (exp_q.size() == 0) fail("tx_byte");
                else check("tx_byte", bus0.tx_data, exp_q.pop_front());
                held = bus0.tx_data;
                hold_cnt = 1;
                bytes_seen++;
            end else if (bus0.tx_start) begin
                hold_cnt++;
                if (bus0.tx_data !== held) data_moved = 1'b1;
            end else if (prev_start) begin
                check("start_hold_len", hold_cnt, start_delay);
                check("data_stable", data_moved, 1'b0);
                data_moved = 1'b0;
            end
            if (prev_busy && !bus0.tx_busy) busy_falls++;
            if (bus0.req_ack != '0) begin
                if (ack_q.size() == 0) fail("req_ack");
                else check("req_ack", bus0.req_ack, ack_q.pop_front());
                acks_seen++;
            end
            prev_start = bus0.tx_start;
            prev_busy  = bus0.tx_busy;
        end
    end

    // ---------------- transmitter model + monitor for dut1 ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus1.tx_start && !busy1) begin
                if (exp1_q.size() == 0) fail("dut16_byte");
                else check("dut16_byte", bus1.tx_data, exp1_q.pop_front());
                busy1 = 1'b1;
                repeat (2) @(negedge clk);
                busy1 = 1'b0;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_acks(input int target, input string name);
        int n = 0;
        while (acks_seen < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, acks_seen, target);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus0.frame_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, {exp_q.size() != 0, bus0.frame_busy}, 2'b00);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    // ---------------- main stimulus ----------------
    initial begin
        int base;
        int lat;
        logic start_seen;

        bus0.req = '0;
        bus0.req_data = {W2, W1, W0};
        bus1.req = '0;
        bus1.req_data = '0;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_tx_start", bus0.tx_start, 1'b0);
        check("rst_tx_data", bus0.tx_data, 8'h00);
        check("rst_req_ack", bus0.req_ack, 3'b000);
        check("rst_frame_busy", bus0.frame_busy, 1'b0);
        check("rst_state", state0, IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fairness: 0 and 2 alternate, then 1 joins mid-frame
        base = acks_seen;
        push_frame(0, W0);
        push_frame(2, W2);
        push_frame(0, W0);
        push_frame(2, W2);
        push_frame(0, W0);
        push_frame(1, W1);
        push_frame(2, W2);
        bus0.req = 3'b101;
        wait_acks(base + 4, "fair_acks_a");
        bus0.req = 3'b111;
        wait_acks(base + 7, "fair_acks_b");
        bus0.req = 3'b000;
        wait_idle("fair_idle");

        // Single frame on ch1 with hand-computed bytes; minimum latency
        @(negedge clk);
        busy_falls = 0;
        base = acks_seen;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h56);
        exp_q.push_back(8'h78);
        exp_q.push_back(8'h09);
        ack_q.push_back(3'b010);
        bus0.req = 3'b010;
        lat = 0;
        while (!bus0.tx_start && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("req_to_start_latency", lat, 2);
        bus0.req = 3'b000;
        wait_idle("single_idle");
        check("single_busy_falls", busy_falls, 7);
        check("single_ack_count", acks_seen - base, 1);

        // Slow baud tick: busy rises 40 cycles after start
        start_delay = 40;
        base = acks_seen;
        push_frame(0, W0);
        bus0.req = 3'b001;
        wait_acks(base + 1, "slow_ack");
        bus0.req = 3'b000;
        wait_idle("slow_idle");
        start_delay = 1;

        // Transmitter already busy at grant
        base = acks_seen;
        push_frame(0, W0);
        hold_busy = 1'b1;
        bus0.req = 3'b001;
        wait_acks(base + 1, "busy_grant_ack");
        bus0.req = 3'b000;
        start_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus0.tx_start) start_seen = 1'b1;
        end
        check("busy_grant_no_start", start_seen, 1'b0);
        hold_busy = 1'b0;
        wait_idle("busy_grant_idle");

        // Reset mid-frame after the third byte; ch1 leaves ptr at 2
        base = acks_seen;
        push_frame(1, W1);
        bus0.req = 3'b010;
        wait_acks(base + 1, "rst_mid_ack");
        bus0.req = 3'b000;
        lat = 0;
        base = bytes_seen;
        while (bytes_seen < base + 3 && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        while (!bus0.tx_busy && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        while (bus0.tx_busy && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        check("rst_mid_third_byte", bytes_seen, base + 3);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx_start", bus0.tx_start, 1'b0);
        check("rst_mid_tx_data", bus0.tx_data, 8'h00);
        check("rst_mid_frame_busy", bus0.frame_busy, 1'b0);
        check("rst_mid_state", state0, IDLE);
        exp_q.delete();
        ack_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // ptr back at 0: with ch1 and ch2 requesting, ch1 wins
        base = acks_seen;
        push_frame(1, W1);
        bus0.req = 3'b110;
        wait_acks(base + 1, "post_rst_ack");
        bus0.req = 3'b000;
        wait_idle("post_rst_idle");

        // 16-bit, 2-requester configuration
        exp1_q.push_back(8'hA5);
        exp1_q.push_back(8'h01);
        exp1_q.push_back(8'hBE);
        exp1_q.push_back(8'hEF);
        exp1_q.push_back(8'h50);
        bus1.req_data = {16'hBEEF, 16'h0000};
        bus1.req = 2'b10;
        lat = 0;
        while (bus1.req_ack == '0 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("dut16_ack", bus1.req_ack, 2'b10);
        bus1.req = 2'b00;
        lat = 0;
        while ((exp1_q.size() != 0 || bus1.frame_busy) && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        check("dut16_done", {exp1_q.size() != 0, bus1.frame_busy}, 2'b00);

        repeat (5) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("ack_q_drained", ack_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
